// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - op and state encodings shared by the multiply/divide unit
package muldiv_unit_pkg;

  localparam int          MD_W      = 32;
  localparam logic [31:0] MD_DIV0_Q = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 MULT/DIV unit with architectural HI/LO
// Operates on magnitudes and applies sign correction in a single FIX cycle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int           W      = MD_W,
  parameter logic [W-1:0] DIV0_Q = W'(MD_DIV0_Q)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic         flush,
  input  logic [W-1:0] S,
  input  logic [W-1:0] T,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] HI,
  output logic [W-1:0] LO
);

  md_state_e      state;
  logic [5:0]     cnt;
  logic [2*W-1:0] acc;
  logic [W-1:0]   ra;
  logic [W-1:0]   rb;
  logic           is_div;
  logic           neg_q;
  logic           neg_r;
  logic           div0;

  function automatic logic [W-1:0] neg_if(input logic [W-1:0] x, input logic c);
    return c ? ((~x) + W'(1)) : x;
  endfunction

  function automatic logic [2*W-1:0] neg_if2(input logic [2*W-1:0] x, input logic c);
    return c ? ((~x) + (2*W)'(1)) : x;
  endfunction

  logic         op_md;
  logic         op_div;
  logic         op_signed;
  logic [W-1:0] s_in;
  logic [W-1:0] t_in;

  assign op_md     = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  assign op_div    = (op == MD_DIV) || (op == MD_DIVU);
  assign op_signed = (op == MD_MULT) || (op == MD_DIV);
  assign s_in      = op_signed ? neg_if(S, S[W-1]) : S;
  assign t_in      = op_signed ? neg_if(T, T[W-1]) : T;

  assign busy = (state != MD_IDLE);

  // Shared W+1-bit adder: adds the multiplicand for MULT, subtracts the divisor for DIV.
  logic [W:0]     add_a;
  logic [W:0]     add_b;
  logic           add_cin;
  logic [W+1:0]   add_res;
  logic [W-1:0]   rem;
  logic [2*W-1:0] acc_next;

  always_comb begin
    if (is_div) begin
      add_a   = {acc[2*W-1:W], ra[W-1]};
      add_b   = ~{1'b0, rb};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, acc[2*W-1:W]};
      add_b   = ra[0] ? {1'b0, rb} : '0;
      add_cin = 1'b0;
    end
    add_res = {1'b0, add_a} + {1'b0, add_b} + {{(W+1){1'b0}}, add_cin};
  end

  // Carry out of the subtract means no borrow: keep the difference, quotient bit is 1.
  always_comb begin
    rem = add_res[W+1] ? add_res[W-1:0] : add_a[W-1:0];
    if (is_div) begin
      acc_next = {rem, acc[W-2:0], add_res[W+1]};
    end else begin
      acc_next = {add_res[W:0], acc[W-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      acc    <= '0;
      ra     <= '0;
      rb     <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      done   <= 1'b0;
      HI     <= '0;
      LO     <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= MD_IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          MD_IDLE: begin
            if (start) begin
              if (op_md) begin
                ra     <= op_div ? s_in : t_in;
                rb     <= op_div ? t_in : s_in;
                is_div <= op_div;
                neg_q  <= op_signed & (S[W-1] ^ T[W-1]);
                neg_r  <= op_signed & S[W-1];
                div0   <= (T == '0);
                acc    <= '0;
                cnt    <= '0;
                state  <= MD_RUN;
              end else if (op == MD_MTHI) begin
                HI <= S;
              end else if (op == MD_MTLO) begin
                LO <= S;
              end
            end
          end
          MD_RUN: begin
            acc <= acc_next;
            ra  <= is_div ? {ra[W-2:0], 1'b0} : {1'b0, ra[W-1:1]};
            cnt <= cnt + 6'd1;
            if (cnt == 6'(W-1)) begin
              state <= MD_FIX;
            end
          end
          MD_FIX: begin
            if (is_div) begin
              LO <= div0 ? DIV0_Q : neg_if(acc[W-1:0], neg_q);
              HI <= neg_if(acc[2*W-1:W], neg_r);
            end else begin
              {HI, LO} <= neg_if2(acc, neg_q);
            end
            done  <= 1'b1;
            cnt   <= '0;
            state <= MD_IDLE;
          end
          default: begin
            state <= MD_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit against an arithmetic reference
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic        flush;
  logic [31:0] S;
  logic [31:0] T;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [31:0] hi_m;
  logic [31:0] lo_m;
  logic        done_d = 1'b0;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .flush(flush),
    .S(S), .T(T), .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] s, input logic [31:0] t);
    longint      ss, st, q, r;
    logic [63:0] us, ut;
    ss = longint'($signed(s));
    st = longint'($signed(t));
    us = {32'd0, s};
    ut = {32'd0, t};
    case (o)
      3'd0: return ss * st;
      3'd1: return us * ut;
      3'd2: begin
        if (t == 32'd0) return {s, 32'hFFFFFFFF};
        q = ss / st;
        r = ss % st;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (t == 32'd0) return {s, 32'hFFFFFFFF};
        return {(us % ut) & 64'hFFFFFFFF, 32'd0} >> 0 | {32'd0, (us / ut) & 64'hFFFFFFFF} |
               {((us % ut) & 64'hFFFFFFFF) << 32} & 64'hFFFFFFFF00000000;
      end
      default: return 64'd0;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      check("done_back_to_back", {63'd0, done_d}, 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(exp_q.size()), 64'd1);
      end else begin
        check("result_hi_lo", {HI, LO}, exp_q.pop_front());
      end
    end
    done_d <= done;
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] s, input logic [31:0] t);
    @(negedge clk);
    op = o; S = s; T = t; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    S = $urandom;
    T = $urandom;
  endtask

  task automatic do_muldiv(input logic [2:0] o, input logic [31:0] s, input logic [31:0] t);
    logic [63:0] e;
    e = ref_model(o, s, t);
    exp_q.push_back(e);
    issue(o, s, t);
    check("busy_after_start", {62'd0, busy, done}, 64'd2);
    repeat (32) @(posedge clk);
    #1;
    check("busy_last_cycle", {62'd0, busy, done}, 64'd2);
    check("hi_lo_stable_run", {HI, LO}, {hi_m, lo_m});
    @(posedge clk);
    #1;
    check("done_at_k33", {62'd0, busy, done}, 64'd1);
    {hi_m, lo_m} = e;
  endtask

  initial begin
    logic [31:0] rs, rt, mv;
    logic [2:0]  ro;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; S = '0; T = '0;
    hi_m = '0; lo_m = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {HI, LO}, 64'd0);
    check("reset_flags", {62'd0, busy, done}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_muldiv(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    do_muldiv(MD_MULT,  32'hFFFFFFFD, 32'h00000007);
    do_muldiv(MD_DIV,   32'hFFFFFFF9, 32'h00000002);
    do_muldiv(MD_DIVU,  32'hFFFFFFF9, 32'h00000002);
    do_muldiv(MD_DIV,   32'h00000011, 32'h00000000);
    do_muldiv(MD_DIVU,  32'h80000011, 32'h00000000);
    do_muldiv(MD_DIV,   32'hFFFFFFF0, 32'h00000000);
    do_muldiv(MD_DIV,   32'h80000000, 32'hFFFFFFFF);

    // MTHI/MTLO write on the issue edge without going busy
    issue(MD_MTLO, 32'hCAFEF00D, $urandom);
    lo_m = 32'hCAFEF00D;
    check("mtlo", {HI, LO, 1'b0} >> 1, {hi_m, lo_m});
    issue(MD_MTHI, 32'h12345678, $urandom);
    hi_m = 32'h12345678;
    check("mthi", {HI, LO}, {hi_m, lo_m});
    check("mthi_flags", {62'd0, busy, done}, 64'd0);

    // reserved op is a no-op
    issue(3'd6, 32'hDEADBEEF, 32'h1);
    check("reserved_op", {31'd0, busy, HI}, {31'd0, 1'b0, hi_m});

    // flush mid-run discards the MULT
    issue(MD_MULT, 32'h00001234, 32'h00005678);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check("flush_hi_lo", {HI, LO}, {hi_m, lo_m});

    // flush beats a simultaneous MTHI
    @(negedge clk);
    op = MD_MTHI; S = 32'h0BADF00D; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    check("flush_vs_mthi", {HI, LO}, {hi_m, lo_m});

    // start while busy is ignored
    rs = $urandom; rt = $urandom;
    exp_q.push_back(ref_model(MD_MULTU, rs, rt));
    issue(MD_MULTU, rs, rt);
    repeat (5) @(posedge clk);
    @(negedge clk);
    op = MD_MTHI; S = 32'h55555555; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_while_busy", {HI, LO}, {hi_m, lo_m});
    repeat (26) @(posedge clk);
    #1;
    check("busy_ignored_start", {62'd0, busy, done}, 64'd2);
    @(posedge clk);
    #1;
    check("done_ignored_start", {62'd0, busy, done}, 64'd1);
    {hi_m, lo_m} = ref_model(MD_MULTU, rs, rt);

    // asynchronous reset mid-run
    issue(MD_MULT, $urandom, $urandom);
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", {HI, LO}, 64'd0);
    check("async_reset_flags", {62'd0, busy, done}, 64'd0);
    hi_m = '0; lo_m = '0;
    @(negedge clk);
    rst = 1'b0;
    do_muldiv(MD_DIVU, 32'h00000064, 32'h00000007);

    // randomized operations
    for (int i = 0; i < 30; i++) begin
      ro = 3'($urandom_range(0, 3));
      rs = $urandom;
      rt = $urandom;
      mv = $urandom_range(0, 7);
      if (mv == 0) rt = 32'd0;
      else if (mv == 1) rt = 32'hFFFFFFFF;
      else if (mv == 2) rt = 32'($urandom_range(1, 15));
      else if (mv == 3) rs = 32'h80000000;
      do_muldiv(ro, rs, rt);
    end

    repeat (4) @(posedge clk);
    #1;
    check("pending_results", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
